// File: rtl/da_dct_row_seq_if.sv
// da_dct_row_seq_if: handshake, sample, ROM and coefficient signals of the
// bit-serial DA DCT sequencer. The master modport is the sequencer's view;
// the slave modport is the surrounding system (sample buffer, ROM, RLE stage).
interface da_dct_row_seq_if #(
    parameter int DATA_W = 16,
    parameter int ROM_W  = 16,
    parameter int OUT_W  = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] x0;
    logic signed [DATA_W-1:0] x1;
    logic signed [DATA_W-1:0] x2;
    logic signed [DATA_W-1:0] x3;
    logic [2:0]               rom_addr;
    logic                     rom_cs;
    logic signed [ROM_W-1:0]  rom_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     busy;

    modport master (
        input  in_valid, x0, x1, x2, x3, rom_data, out_ready,
        output in_ready, rom_addr, rom_cs, out_valid, out_data, busy
    );

    modport slave (
        output in_valid, x0, x1, x2, x3, rom_data, out_ready,
        input  in_ready, rom_addr, rom_cs, out_valid, out_data, busy
    );
endinterface

// File: rtl/da_dct_row_seq.sv
// da_dct_row_seq: bit-serial distributed-arithmetic sequencer producing one
// 4-point DCT coefficient. Latches four signed samples, walks their bit
// slices MSB-first, addresses an offset-binary coefficient ROM once per bit
// and shift-accumulates the returned words.
// Optional feature: define DA_SAT_EN to saturate the output to the signed
// OUT_W range instead of wrapping (truncating) it.
module da_dct_row_seq #(
    parameter int DATA_W  = 16,
    parameter int ROM_W   = 16,
    parameter int ACC_W   = 33,
    parameter int OUT_W   = 16,
    parameter int FRAC_SH = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    da_dct_row_seq_if.master bus
);
    localparam int            JW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [JW-1:0] J_MSB = JW'(DATA_W - 1);

`ifdef DA_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic signed [DATA_W-1:0] x0_q, x0_d;
    logic signed [DATA_W-1:0] x1_q, x1_d;
    logic signed [DATA_W-1:0] x2_q, x2_d;
    logic signed [DATA_W-1:0] x3_q, x3_d;
    logic [JW-1:0]            j_q, j_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [OUT_W-1:0]  out_q, out_d;

    logic signed [ACC_W-1:0]  rom_ext;
    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  acc_sh;
    logic [2:0]               rom_addr_c;
    logic                     in_ready_c;
    logic                     rom_cs_c;
    logic                     out_valid_c;
    logic                     busy_c;

    // Scale the finished accumulator down by FRAC_SH and fit it to OUT_W.
    function automatic logic signed [OUT_W-1:0] shape_out(input logic signed [ACC_W-1:0] a);
`ifdef DA_SAT_EN
        logic signed [ACC_W-1:0] s;
        s = a >>> FRAC_SH;
        if (s > SAT_MAX) begin
            return SAT_MAX[OUT_W-1:0];
        end
        if (s < SAT_MIN) begin
            return SAT_MIN[OUT_W-1:0];
        end
        return s[OUT_W-1:0];
`else
        return OUT_W'(a >>> FRAC_SH);
`endif
    endfunction

    // Next state, datapath update and state-decoded outputs.
    always_comb begin
        state_d     = state_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        x3_d        = x3_q;
        j_d         = j_q;
        acc_d       = acc_q;
        out_d       = out_q;
        rom_ext     = '0;
        term        = '0;
        acc_sh      = '0;
        rom_addr_c  = 3'b000;
        in_ready_c  = 1'b0;
        rom_cs_c    = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    x0_d    = bus.x0;
                    x1_d    = bus.x1;
                    x2_d    = bus.x2;
                    x3_d    = bus.x3;
                    acc_d   = '0;
                    j_d     = J_MSB;
                    state_d = ITER;
                end
            end

            ITER: begin
                rom_cs_c = 1'b1;
                busy_c   = 1'b1;
                // Offset-binary addressing: x0's bit selects the sign of the
                // ROM word, the other three bits are taken relative to it.
                rom_addr_c = {x1_q[j_q] ^ x0_q[j_q],
                              x2_q[j_q] ^ x0_q[j_q],
                              x3_q[j_q] ^ x0_q[j_q]};
                rom_ext = {{(ACC_W-ROM_W){bus.rom_data[ROM_W-1]}}, bus.rom_data};
                term    = x0_q[j_q] ? -rom_ext : rom_ext;
                acc_sh  = acc_q <<< 1;
                // The sign-bit slice carries negative weight.
                acc_d   = (j_q == J_MSB) ? (acc_sh - term) : (acc_sh + term);
                if (j_q == '0) begin
                    out_d   = shape_out(acc_d);
                    state_d = OUT;
                end else begin
                    j_d = j_q - JW'(1);
                end
            end

            OUT: begin
                out_valid_c = 1'b1;
                busy_c      = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched samples, bit counter, accumulator and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x0_q    <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            x3_q    <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            x3_q    <= x3_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.rom_cs    = rom_cs_c;
    assign bus.rom_addr  = rom_addr_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_q;
    assign bus.busy      = busy_c;
endmodule

// File: tb/tb_da_dct_row_seq.sv
// tb_da_dct_row_seq: table-driven, hand-sequenced and randomized checks of
// the DA DCT sequencer against a weighted-sum reference model.
module tb_da_dct_row_seq;
    localparam int DW = 16;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    da_dct_row_seq_if #(.DATA_W(DW), .ROM_W(16), .OUT_W(16)) bus ();

    da_dct_row_seq #(
        .DATA_W (DW),
        .ROM_W  (16),
        .ACC_W  (33),
        .OUT_W  (16),
        .FRAC_SH(0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Coefficient ROM contents.
    function automatic logic signed [15:0] rom_word(input logic [2:0] a);
        case (a)
            3'b001:                 return 16'sh2D41;
            3'b010, 3'b100, 3'b111: return 16'shD2BE;
            3'b110:                 return 16'shA57D;
            default:                return 16'sh0000;
        endcase
    endfunction

    // Combinational ROM; garbage when deselected.
    always_comb begin
        bus.rom_data = bus.rom_cs ? rom_word(bus.rom_addr) : 16'shDEAD;
    end

    function automatic logic [2:0] exp_addr(input logic signed [15:0] a, b, c, d, input int j);
        return {b[j] ^ a[j], c[j] ^ a[j], d[j] ^ a[j]};
    endfunction

    // Reference: coefficient = sum over bit positions of weight * signed term,
    // with the MSB weight negative; then wrap or clamp to 16 bits.
    function automatic logic signed [15:0] ref_coef(input logic signed [15:0] a, b, c, d);
        longint acc;
        longint r;
        longint w;
        acc = 0;
        for (int j = 0; j < DW; j++) begin
            r = longint'(rom_word(exp_addr(a, b, c, d, j)));
            if (a[j]) r = -r;
            w = longint'(1) << j;
            if (j == DW - 1) w = -w;
            acc += w * r;
        end
`ifdef DA_SAT_EN
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
`endif
        return acc[15:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One full transaction: accept, 16 ITER cycles, OUT with optional stall.
    task automatic send(input logic signed [15:0] a, b, c, d,
                        input logic signed [15:0] exp, input int stall, input string tag);
        @(negedge clk);
        chk($sformatf("%s_rdy", tag), {31'd0, bus.in_ready}, 32'd1);
        bus.x0 = a; bus.x1 = b; bus.x2 = c; bus.x3 = d;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        // Scramble samples and keep in_valid high: must not be re-latched.
        bus.x0 = 16'($urandom); bus.x1 = 16'($urandom);
        bus.x2 = 16'($urandom); bus.x3 = 16'($urandom);
        for (int k = 0; k < DW; k++) begin
            @(negedge clk);
            chk($sformatf("%s_iter%0d", tag, k),
                {26'd0, bus.busy, bus.rom_cs, bus.out_valid, bus.in_ready, bus.rom_addr},
                {26'd0, 1'b1, 1'b1, 1'b0, 1'b0, exp_addr(a, b, c, d, DW - 1 - k)});
        end
        // Counting the accept edge, out_valid rises on the DW+1-th edge.
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk($sformatf("%s_ov", tag), {29'd0, bus.out_valid, bus.rom_cs, bus.busy}, 32'b101);
        chk($sformatf("%s_data", tag), 32'(bus.out_data), 32'(exp));
        if (stall > 0) begin
            bus.out_ready = 1'b0;
            for (int s = 1; s <= stall; s++) begin
                @(negedge clk);
                chk($sformatf("%s_hold%0d", tag, s),
                    {30'd0, bus.out_valid, bus.in_ready}, 32'b10);
                chk($sformatf("%s_hdata%0d", tag, s), 32'(bus.out_data), 32'(exp));
                bus.in_valid = 1'b1;
                bus.x0 = 16'($urandom); bus.x3 = 16'($urandom);
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        chk($sformatf("%s_done", tag),
            {29'd0, bus.in_ready, bus.out_valid, bus.busy}, 32'b100);
    endtask

    typedef struct {
        logic signed [15:0] x0, x1, x2, x3;
        logic signed [15:0] exp;
        int                 stall;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic signed [15:0] a, b, c, d;
        n_vec = 0;
        n_bad = 0;

        tbl[0] = '{16'sd0,      16'sd0,      16'sd0,      16'sd0,  16'sd0,      0};
        tbl[1] = '{16'sd0,      16'sd0,      16'sd0,      16'sd1,  16'sd11585,  0};
        tbl[2] = '{16'sd0,      16'sd0,      16'sd0,      -16'sd1, -16'sd11585, 2};
        tbl[3] = '{16'sd1,      16'sd0,      16'sd0,      16'sd0,  16'sd11586,  0};
`ifdef DA_SAT_EN
        tbl[4] = '{16'sd0, 16'sh8000, 16'sh8000, 16'sd0, 16'sh7FFF, 5};
`else
        tbl[4] = '{16'sd0, 16'sh8000, 16'sh8000, 16'sd0, 16'sh8000, 5};
`endif
        tbl[5] = '{16'sd0,      16'sd0,      16'sd0,      16'sd1,  16'sd11585,  1};

        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.x0 = '0; bus.x1 = '0; bus.x2 = '0; bus.x3 = '0;
        #12;
        chk("reset_state",
            {12'd0, bus.in_ready, bus.out_valid, bus.rom_cs, bus.busy, bus.rom_addr, 16'(bus.out_data)},
            {12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 16'd0});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            send(tbl[i].x0, tbl[i].x1, tbl[i].x2, tbl[i].x3, tbl[i].exp, tbl[i].stall,
                 $sformatf("tbl%0d", i));
        end

        // Reset in the middle of ITER (bit counter at 7).
        @(negedge clk);
        bus.x0 = 16'sh1234; bus.x1 = 16'sh8765; bus.x2 = 16'sh0F0F; bus.x3 = 16'sh7FFF;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_iter_cs", {31'd0, bus.rom_cs}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset",
            {12'd0, bus.in_ready, bus.out_valid, bus.rom_cs, bus.busy, bus.rom_addr, 16'(bus.out_data)},
            {12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 16'd0});
        @(negedge clk);
        rst_n = 1'b1;
        send(16'sh1234, 16'sh8765, 16'sh0F0F, 16'sh7FFF,
             ref_coef(16'sh1234, 16'sh8765, 16'sh0F0F, 16'sh7FFF), 0, "post_rst");

        // Randomized sets with random back-pressure.
        for (int i = 0; i < 20; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            c = 16'($urandom); d = 16'($urandom);
            if (i == 0) begin a = 16'sh8000; b = 16'sh7FFF; c = 16'sh8000; d = 16'sh7FFF; end
            if (i == 1) begin a = -16'sd1; b = -16'sd1; c = -16'sd1; d = -16'sd1; end
            send(a, b, c, d, ref_coef(a, b, c, d), int'($urandom_range(0, 3)),
                 $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
